bsg_dram_ch_req_arbiter: RTL
============================

BSG_DRAM_CH_REQ_ARBITER -- requirements
Module: bsg_dram_ch_req_arbiter

Interface
REQ-001 The block SHALL have parameter num_req_p, default 4, number of requesters sharing one DRAM channel (>=2).
REQ-002 The block SHALL have parameter ch_addr_width_p, default 29, DRAM channel address width.
REQ-003 The block SHALL have parameter max_outstanding_p, default 16, maximum in-flight requests (>=1).
REQ-004 The block SHALL have parameter counter_width_p, default 32, width of the sent/recv statistics counters.
REQ-005 The block SHALL have port clk_i  input  1  clock, all state on posedge.
REQ-006 The block SHALL have port reset_i  input  1  reset, synchronous, active-high.
REQ-007 The block SHALL have port v_i  input  num_req_p  per-requester request valid.
REQ-008 The block SHALL have port write_not_read_i  input  num_req_p  per-requester op: 1=write, 0=read.
REQ-009 The block SHALL have port ch_addr_i  input  num_req_p x ch_addr_width_p  per-requester channel address.
REQ-010 The block SHALL have port yumi_o  output  num_req_p  per-requester accept.
REQ-011 The block SHALL have port v_o  output  1  request valid to DRAM channel.
REQ-012 The block SHALL have port write_not_read_o  output  1  op of the granted request.
REQ-013 The block SHALL have port ch_addr_o  output  ch_addr_width_p  address of the granted request.
REQ-014 The block SHALL have port yumi_i  input  1  DRAM channel accept, valid only while v_o=1.
REQ-015 The block SHALL have port data_v_i  input  1  DRAM read-data return pulse.
REQ-016 The block SHALL have port write_done_i  input  1  DRAM write-completion pulse.
REQ-017 The block SHALL have port outstanding_o  output  clog2(max_outstanding_p+1)  in-flight request count.
REQ-018 The block SHALL have ports sent_o and recv_o  output  counter_width_p each  accepted requests and received completions.
REQ-019 The block SHALL have port idle_o  output  1  no pending or in-flight work.
REQ-020 The block SHALL have port error_o  output  1  sticky protocol error.

Function
REQ-021 Handshake SHALL be valid-then-yumi on both sides; requesters hold v_i and payload stable until their yumi_o.
REQ-022 Arbitration SHALL be round-robin: search starts at pointer rr_r, first requester with v_i=1 at or after rr_r (wrapping) is selected.
REQ-023 v_o SHALL equal (any v_i or lock_r) and (outstanding_o < max_outstanding_p); payload outputs mux from the selected requester.
REQ-024 If v_o=1 and yumi_i=0, the selection SHALL be latched (lock_r=1, sel_r) and held next cycle regardless of new higher-priority requests.
REQ-025 yumi_o[sel] SHALL equal v_o & yumi_i, combinationally, same cycle; all other yumi_o bits 0; at most one bit high.
REQ-026 On accept (v_o & yumi_i): rr_r SHALL become (sel+1) mod num_req_p, lock_r cleared, sent_o +1.
REQ-027 outstanding_o next value SHALL be outstanding + accept - data_v_i - write_done_i; both completions in one cycle decrement by 2; simultaneous accept and completion net correctly.
REQ-028 At outstanding_o == max_outstanding_p, v_o SHALL be 0 and no yumi_o asserted; a completion in that cycle allows issue in the following cycle, not the same cycle.
REQ-029 recv_o SHALL increment by data_v_i + write_done_i each cycle; sent_o and recv_o wrap modulo 2^counter_width_p.
REQ-030 A completion that would drive outstanding below 0 SHALL set error_o (sticky until reset) and saturate outstanding at 0.
REQ-031 idle_o SHALL be 1 iff outstanding_o==0, v_i==0 and lock_r==0.
REQ-032 Latency request-to-DRAM SHALL be 0 cycles (combinational pass-through when credit available).

Reset
REQ-033 While reset_i=1: v_o=0, yumi_o=0, outstanding_o=0, sent_o=0, recv_o=0, error_o=0, idle_o=1 if v_i==0, rr_r=0, lock_r=0.
REQ-034 Reset asserted mid-operation SHALL discard in-flight accounting and lock; completions arriving in the reset cycle are ignored.

Verification
REQ-035 All 4 requesters valid continuously, yumi_i=1 always, max_outstanding_p=16, completions immediate next cycle -> grant order 0,1,2,3,0,... one per cycle, no requester starved.
REQ-036 Requester 2 valid, yumi_i=0 for 3 cycles while requester 0 raises v_i -> selection stays 2 until accepted, then 0 after rr wraps.
REQ-037 16 accepts with no completions -> outstanding_o=16, v_o=0, yumi_o=0; one data_v_i -> v_o=1 the next cycle.
REQ-038 data_v_i and write_done_i same cycle as an accept with outstanding_o=5 -> outstanding_o=4, recv_o +2, sent_o +1.
REQ-039 write_done_i with outstanding_o=0 -> error_o=1, outstanding_o stays 0, error_o holds until reset_i.
REQ-040 Reset asserted with outstanding_o=7 and lock_r=1 -> next cycle outstanding_o=0, sent_o=recv_o=0, grant restarts at requester 0.

Source files
------------

// File: rtl/bsg_dram_ch_req_arbiter.sv
// bsg_dram_ch_req_arbiter
//
// Round-robin arbiter that lets num_req_p requesters share one DRAM channel,
// with a credit limit on in-flight requests and completion accounting.
//
// Ports:
//   clk_i, reset_i           clock; synchronous active-high reset
//   v_i, write_not_read_i,   per-requester valid, op (1=write) and address
//   ch_addr_i
//   yumi_o                   per-requester accept, one-hot or zero
//   v_o, write_not_read_o,   granted request towards the DRAM channel
//   ch_addr_o
//   yumi_i                   DRAM channel accept of the presented request
//   data_v_i, write_done_i   read-data return and write-completion pulses
//   outstanding_o            in-flight request count
//   sent_o, recv_o           wrapping accepted/completed statistics counters
//   idle_o                   nothing pending, locked or in flight
//   error_o                  sticky completion-underflow error

module bsg_dram_ch_req_arbiter #(
    parameter int unsigned num_req_p         = 4,
    parameter int unsigned ch_addr_width_p   = 29,
    parameter int unsigned max_outstanding_p = 16,
    parameter int unsigned counter_width_p   = 32
) (
    input  logic                                          clk_i,
    input  logic                                          reset_i,
    input  logic [num_req_p-1:0]                          v_i,
    input  logic [num_req_p-1:0]                          write_not_read_i,
    input  logic [num_req_p-1:0][ch_addr_width_p-1:0]     ch_addr_i,
    output logic [num_req_p-1:0]                          yumi_o,
    output logic                                          v_o,
    output logic                                          write_not_read_o,
    output logic [ch_addr_width_p-1:0]                    ch_addr_o,
    input  logic                                          yumi_i,
    input  logic                                          data_v_i,
    input  logic                                          write_done_i,
    output logic [$clog2(max_outstanding_p+1)-1:0]        outstanding_o,
    output logic [counter_width_p-1:0]                    sent_o,
    output logic [counter_width_p-1:0]                    recv_o,
    output logic                                          idle_o,
    output logic                                          error_o
);

    localparam int unsigned sel_width_lp = $clog2(num_req_p);
    localparam int unsigned out_width_lp = $clog2(max_outstanding_p+1);
    localparam int unsigned out_ext_lp   = out_width_lp + 1;

    logic [sel_width_lp-1:0]    rr_r, sel_r, rr_sel, sel, rr_n;
    logic                       lock_r;
    logic [out_width_lp-1:0]    out_r, out_n;
    logic [counter_width_p-1:0] sent_r, recv_r;
    logic                       error_r;

    logic                       credit, accept, found, underflow;
    logic [out_ext_lp-1:0]      out_up;
    logic [1:0]                 done_cnt;
    int                         idx;

    // First valid requester at or after rr_r, wrapping.
    always_comb begin
        rr_sel = rr_r;
        found  = 1'b0;
        idx    = 0;
        for (int i = 0; i < num_req_p; i++) begin
            idx = (int'(rr_r) + i) % int'(num_req_p);
            if (!found && v_i[idx]) begin
                rr_sel = sel_width_lp'(idx);
                found  = 1'b1;
            end
        end
    end

    // A presented-but-unaccepted request is held until the channel takes it.
    assign sel    = lock_r ? sel_r : rr_sel;
    assign credit = (out_r < out_width_lp'(max_outstanding_p));
    assign v_o    = ~reset_i & ((|v_i) | lock_r) & credit;
    assign accept = v_o & yumi_i;

    assign write_not_read_o = write_not_read_i[sel];
    assign ch_addr_o        = ch_addr_i[sel];

    always_comb begin
        yumi_o      = '0;
        yumi_o[sel] = accept;
    end

    assign rr_n = (int'(sel) == int'(num_req_p) - 1) ? '0 : sel + 1'b1;

    // Extra bit on out_up so a decrement below zero is detectable.
    always_comb begin
        out_up    = {1'b0, out_r} + out_ext_lp'(accept);
        done_cnt  = {1'b0, data_v_i} + {1'b0, write_done_i};
        underflow = (out_up < out_ext_lp'(done_cnt));
        out_n     = underflow ? '0 : out_width_lp'(out_up - out_ext_lp'(done_cnt));
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            rr_r    <= '0;
            sel_r   <= '0;
            lock_r  <= 1'b0;
            out_r   <= '0;
            sent_r  <= '0;
            recv_r  <= '0;
            error_r <= 1'b0;
        end else begin
            out_r  <= out_n;
            sent_r <= sent_r + counter_width_p'(accept);
            recv_r <= recv_r + counter_width_p'(done_cnt);
            if (underflow) begin
                error_r <= 1'b1;
            end
            if (accept) begin
                rr_r   <= rr_n;
                lock_r <= 1'b0;
            end else if (v_o) begin
                lock_r <= 1'b1;
                sel_r  <= sel;
            end
        end
    end

    // Status outputs read as cleared for the whole reset cycle.
    assign outstanding_o = reset_i ? '0 : out_r;
    assign sent_o        = reset_i ? '0 : sent_r;
    assign recv_o        = reset_i ? '0 : recv_r;
    assign error_o       = ~reset_i & error_r;
    assign idle_o        = ~(|v_i) & (reset_i | ((out_r == '0) & ~lock_r));

endmodule
